// File: rtl/nibble_serial_adder_if.sv
// rtl/nibble_serial_adder_if.sv - operand/result handshake and adder4bit drive bundle
interface nibble_serial_adder_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic [3:0]   add_av;
    logic [3:0]   add_bv;
    logic         add_cin;
    logic [3:0]   add_sumv;
    logic         add_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;

    // master: operand source, result sink and the external 4-bit adder
    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready, add_sumv, add_cout,
        input  in_ready, add_av, add_bv, add_cin, out_valid, out_sum, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready, add_sumv, add_cout,
        output in_ready, add_av, add_bv, add_cin, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - sequences one external 4-bit adder over 4*NIBBLES-bit operands
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    nibble_serial_adder_if.slave  bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [KW-1:0] k;
    logic [W-1:0]  a_q, b_q, sum_q;
    logic          cin_q, carry_q, cout_q, ovf_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = RUN;
            RUN:     if (k == K_LAST) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.add_av    = 4'h0;
        bus.add_bv    = 4'h0;
        bus.add_cin   = 1'b0;
        if (state == RUN) begin
            for (int i = 0; i < NIBBLES; i++) begin
                if (k == i[KW-1:0]) begin
                    bus.add_av = a_q[4*i +: 4];
                    bus.add_bv = b_q[4*i +: 4];
                end
            end
            // nibble 0 takes the caller's carry-in, later nibbles the chained carry
            bus.add_cin = (k == '0) ? cin_q : carry_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k       <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q   <= bus.in_a;
                        b_q   <= bus.in_b;
                        cin_q <= bus.in_cin;
                        k     <= '0;
                        sum_q <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (k == i[KW-1:0]) sum_q[4*i +: 4] <= bus.add_sumv;
                    end
                    carry_q <= bus.add_cout;
                    k       <= k + 1'b1;
                    if (k == K_LAST) begin
                        cout_q <= bus.add_cout;
                        ovf_q  <= (a_q[W-1] == b_q[W-1]) && (bus.add_sumv[3] != a_q[W-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out_sum  = sum_q;
    assign bus.out_cout = cout_q;
    assign bus.out_ovf  = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - directed and random checks of nibble_serial_adder, NIBBLES=4 and 1
module tb_nibble_serial_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    nibble_serial_adder_if #(.W(16)) bus4 ();
    nibble_serial_adder_if #(.W(4))  bus1 ();

    nibble_serial_adder #(.NIBBLES(4)) dut4 (.clk(clk), .reset(rst_n), .bus(bus4.slave));
    nibble_serial_adder #(.NIBBLES(1)) dut1 (.clk(clk), .reset(rst_n), .bus(bus1.slave));

    // behavioural stand-in for adder4bit
    assign {bus4.add_cout, bus4.add_sumv} = {1'b0, bus4.add_av} + {1'b0, bus4.add_bv} + {4'h0, bus4.add_cin};
    assign {bus1.add_cout, bus1.add_sumv} = {1'b0, bus1.add_av} + {1'b0, bus1.add_bv} + {4'h0, bus1.add_cin};

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t q4[$];
    exp_t q1[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int w, input int a, input int b, input int cin);
        exp_t e;
        int   s;
        s      = a + b + cin;
        e.sum  = 16'(s & ((1 << w) - 1));
        e.cout = s[w];
        e.ovf  = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
        return e;
    endfunction

    // leaves the bench at the negedge right after the accept edge
    task automatic start4(input int a, input int b, input int cin);
        @(negedge clk);
        check("idle_in_ready", 32'(bus4.in_ready), 1);
        check("idle_add_av", 32'(bus4.add_av), 0);
        bus4.in_valid = 1'b1;
        bus4.in_a     = 16'(a);
        bus4.in_b     = 16'(b);
        bus4.in_cin   = cin[0];
        q4.push_back(model(16, a, b, cin));
        @(negedge clk);
        bus4.in_valid = 1'b0;
        bus4.in_a     = ~bus4.in_a;
        bus4.in_b     = ~bus4.in_b;
    endtask

    task automatic wait4(input int a, input int b, input int cin);
        int   cyc;
        int   ci;
        exp_t e;
        for (cyc = 0; cyc < 20 && !bus4.out_valid; cyc++) begin
            if (cyc < 4) begin
                ci = (cyc == 0) ? cin : (((a & ((1 << (4*cyc)) - 1)) + (b & ((1 << (4*cyc)) - 1)) + cin) >> (4*cyc)) & 1;
                check("drive_av", 32'(bus4.add_av), (a >> (4*cyc)) & 15);
                check("drive_bv", 32'(bus4.add_bv), (b >> (4*cyc)) & 15);
                check("drive_cin", 32'(bus4.add_cin), ci);
                check("run_in_ready", 32'(bus4.in_ready), 0);
            end
            @(negedge clk);
        end
        check("latency4", cyc, 4);
        if (q4.size() == 0) begin
            check("scoreboard4_empty", 1, 0);
        end else begin
            e = q4.pop_front();
            check("sum4", 32'(bus4.out_sum), 32'(e.sum));
            check("cout4", 32'(bus4.out_cout), 32'(e.cout));
            check("ovf4", 32'(bus4.out_ovf), 32'(e.ovf));
        end
    endtask

    task automatic release4();
        logic [15:0] held;
        held = bus4.out_sum;
        bus4.out_ready = 1'b1;
        @(negedge clk);
        bus4.out_ready = 1'b0;
        check("release_valid", 32'(bus4.out_valid), 0);
        check("release_in_ready", 32'(bus4.in_ready), 1);
        check("release_sum_kept", 32'(bus4.out_sum), 32'(held));
    endtask

    task automatic op4(input int a, input int b, input int cin);
        start4(a, b, cin);
        wait4(a, b, cin);
        release4();
    endtask

    task automatic op1(input int a, input int b, input int cin);
        int   cyc;
        exp_t e;
        @(negedge clk);
        bus1.in_valid = 1'b1;
        bus1.in_a     = 4'(a);
        bus1.in_b     = 4'(b);
        bus1.in_cin   = cin[0];
        q1.push_back(model(4, a, b, cin));
        @(negedge clk);
        bus1.in_valid = 1'b0;
        for (cyc = 0; cyc < 10 && !bus1.out_valid; cyc++) @(negedge clk);
        check("latency1", cyc, 1);
        e = q1.pop_front();
        check("sum1", 32'(bus1.out_sum), 32'(e.sum[3:0]));
        check("cout1", 32'(bus1.out_cout), 32'(e.cout));
        check("ovf1", 32'(bus1.out_ovf), 32'(e.ovf));
        bus1.out_ready = 1'b1;
        @(negedge clk);
        bus1.out_ready = 1'b0;
        check("release1_valid", 32'(bus1.out_valid), 0);
    endtask

    initial begin
        int a, b, c;
        bus4.in_valid = 0; bus4.in_a = 0; bus4.in_b = 0; bus4.in_cin = 0; bus4.out_ready = 0;
        bus1.in_valid = 0; bus1.in_a = 0; bus1.in_b = 0; bus1.in_cin = 0; bus1.out_ready = 0;

        repeat (2) @(negedge clk);
        check("rst_sum", 32'(bus4.out_sum), 0);
        check("rst_valid", 32'(bus4.out_valid), 0);
        check("rst_cout", 32'(bus4.out_cout), 0);
        check("rst_ovf", 32'(bus4.out_ovf), 0);
        check("rst_in_ready", 32'(bus4.in_ready), 1);
        check("rst_add_cin", 32'(bus4.add_cin), 0);
        rst_n = 1'b1;

        op4(16'h00FF, 16'h0001, 0);
        op4(16'hFFFF, 16'h0001, 0);
        op4(16'h7FFF, 16'h0001, 0);
        op4(16'h8000, 16'h8000, 0);

        start4(16'h1234, 16'h4321, 1);
        wait4(16'h1234, 16'h4321, 1);
        for (int i = 0; i < 3; i++) begin
            bus4.in_valid = ~bus4.in_valid;
            bus4.in_a     = bus4.in_a ^ 16'hA5A5;
            @(negedge clk);
            check("bp_sum", 32'(bus4.out_sum), 32'h5556);
            check("bp_in_ready", 32'(bus4.in_ready), 0);
            check("bp_valid", 32'(bus4.out_valid), 1);
        end
        bus4.in_valid = 1'b0;
        release4();

        start4(16'hABCD, 16'h1111, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_sum", 32'(bus4.out_sum), 0);
        check("abort_valid", 32'(bus4.out_valid), 0);
        check("abort_cout", 32'(bus4.out_cout), 0);
        check("abort_add_av", 32'(bus4.add_av), 0);
        void'(q4.pop_front());
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("abort_no_valid", 32'(bus4.out_valid), 0);
        end
        op4(16'h0001, 16'h0001, 0);

        for (int n = 0; n < 1000; n++) begin
            a = int'($urandom_range(0, 65535));
            b = int'($urandom_range(0, 65535));
            c = int'($urandom_range(0, 1));
            op4(a, b, c);
        end

        op1(4'hF, 4'h1, 0);
        op1(4'h7, 4'h1, 0);
        for (int n = 0; n < 1000; n++) begin
            op1(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Sequencer stage wrapped around the existing 4-bit ripple adder (adder4bit). It feeds that adder and consumes its result.
- Accepts two wide operands through a valid/ready handshake. Drives the adder one nibble per cycle, LSB nibble first, and chains the carry through a register.
- Assembles the wide sum and presents it downstream with carry-out and signed overflow.
- Lets one 4-bit adder instance perform 4*NIBBLES-bit additions.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operation; operand width W = 4*NIBBLES; legal range 1..8.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  input  1  operand set valid.
- in_ready  output  1  block can accept operands.
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- in_cin  input  1  carry-in to least-significant nibble.
- add_av  output  4  nibble A driven to adder4bit.av.
- add_bv  output  4  nibble B driven to adder4bit.bv.
- add_cin  output  1  carry driven to adder4bit.cin.
- add_sumv  input  4  adder4bit.sumv.
- add_cout  input  1  adder4bit.cout.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_sum  output  W  assembled sum.
- out_cout  output  1  carry out of MSB nibble.
- out_ovf  output  1  two's-complement overflow.

Behaviour:
- States: IDLE, RUN, DONE. Nibble counter k, width ceil(log2(NIBBLES)) with a minimum of 1.
- Reset (reset=0, asynchronous):
  - state=IDLE, k=0, carry register=0, operand registers=0.
  - out_sum=0, out_cout=0, out_ovf=0, out_valid=0.
- Handshake signals:
  - in_ready=1 only in IDLE (combinational from state).
  - out_valid=1 only in DONE.
- IDLE:
  - On an edge with in_valid=1, latch in_a, in_b and in_cin, clear k, clear out_sum, and go to RUN.
  - in_valid=0: remain in IDLE.
- RUN (combinational adder drive):
  - add_av = A[4k+3:4k].
  - add_bv = B[4k+3:4k].
  - add_cin = latched cin when k=0, else the carry register.
- RUN (each edge):
  - out_sum[4k+3:4k] <= add_sumv.
  - carry register <= add_cout.
  - k <= k+1.
- RUN exit, on the edge where k=NIBBLES-1:
  - out_cout <= add_cout.
  - out_ovf <= (A[W-1]==B[W-1]) && (add_sumv[3] != A[W-1]).
  - Go to DONE.
- Adder drive outside RUN: add_av, add_bv and add_cin are held at 0.
- Latency: operands accepted at edge t. Nibble k is captured at edge t+1+k. out_valid rises after edge t+NIBBLES. Throughput is one operation per NIBBLES+2 cycles minimum.
- DONE:
  - out_sum, out_cout and out_ovf are held stable while out_valid=1 and out_ready=0.
  - On an edge with out_ready=1, go to IDLE. Outputs retain their values, but out_valid drops.
- No bypass: in_valid is ignored in RUN and DONE, and a DONE->IDLE transition never accepts new operands on the same edge.
- Operands on in_a, in_b and in_cin may change freely after acceptance; only the latched copies are used.
- Reset asserted in RUN or DONE aborts the operation immediately. No out_valid pulse follows, and the block returns to IDLE after release.
- The adder is assumed purely combinational, with the result settled within one clk period.

Test Plan (NIBBLES=4, connected to adder4bit):
- 0x00FF + 0x0001, cin=0:
  - Adder drive sequence: av/bv = F/1, F/0, 0/0, 0/0.
  - Result: out_sum=0x0100, out_cout=0, out_ovf=0.
  - out_valid is high exactly 4 cycles after the accept edge.
- 0xFFFF + 0x0001, cin=0 -> out_sum=0x0000, out_cout=1, out_ovf=0. Carry propagates through all 4 nibbles.
- Signed overflow:
  - 0x7FFF + 0x0001 -> out_sum=0x8000, out_ovf=1, out_cout=0.
  - 0x8000 + 0x8000 -> out_sum=0x0000, out_ovf=1, out_cout=1.
- 0x1234 + 0x4321, cin=1 -> out_sum=0x5556, out_cout=0. add_cin=1 only on nibble 0.
- Backpressure:
  - Hold out_ready=0 for 3 cycles in DONE while toggling in_valid and in_a.
  - out_sum stays 0x5556 and in_ready stays 0.
  - Set out_ready=1: IDLE next cycle.
- Assert reset=0 mid-RUN (k=2):
  - All outputs go to 0 immediately, with no out_valid.
  - After release, a new 0x0001+0x0001 yields 0x0002.
- Randomised sweep: compare out_sum/out_cout against in_a+in_b+in_cin for 1000 operand sets. Repeat with NIBBLES=1 (behaves as a registered 4-bit add, 1-cycle RUN).
